// File: rtl/ctrl_ajuste_campos.sv
// Edit-mode sequencer for the clock/calendar field counters: turns debounced
// button levels into a field select, single-cycle up/down pulses and a blink flag.
module ctrl_ajuste_campos #(
  parameter int unsigned N_FIELDS      = 3,
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000,
  parameter int unsigned BLINK_HALF    = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [3:0] en_count,
  output logic       enUP,
  output logic       enDOWN,
  output logic       editing,
  output logic       blink
);

  localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned BW   = $clog2(BLINK_HALF + 1);
  localparam int unsigned FW   = 4;

  typedef enum logic [1:0] {IDLE, EDIT, HOLD, REPEAT} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [FW-1:0] field_d;
  logic          up_d, down_d, blink_d, pulse;
  logic          mode_q, left_q, right_q, up_q, down_q;
  logic          mode_edge, left_edge, right_edge;
  dir_t          dir, dir_prev;

  // Held direction; both buttons together count as no request
  always_comb begin
    dir = DIR_NONE;
    if (btn_up && !btn_down)      dir = DIR_UP;
    else if (btn_down && !btn_up) dir = DIR_DOWN;
    dir_prev = DIR_NONE;
    if (up_q && !down_q)      dir_prev = DIR_UP;
    else if (down_q && !up_q) dir_prev = DIR_DOWN;
  end

  assign mode_edge  = btn_mode  && !mode_q;
  assign left_edge  = btn_left  && !left_q;
  assign right_edge = btn_right && !right_q;

  // Next-state, field, timer and pulse logic
  always_comb begin
    state_d = state_q;
    field_d = en_count;
    timer_d = timer_q;
    pulse   = 1'b0;
    case (state_q)
      IDLE: begin
        field_d = '0;
        timer_d = '0;
        if (mode_edge) begin
          state_d = EDIT;
          field_d = FW'(1);
        end
      end
      EDIT: begin
        if (mode_edge) begin
          state_d = IDLE;
        end else if (dir != DIR_NONE && dir_prev == DIR_NONE) begin
          pulse   = 1'b1;
          timer_d = '0;
          state_d = HOLD;
        end else if (dir == DIR_NONE && right_edge && !left_edge) begin
          field_d = (en_count == FW'(N_FIELDS)) ? FW'(1) : en_count + FW'(1);
        end else if (dir == DIR_NONE && left_edge && !right_edge) begin
          field_d = (en_count == FW'(1)) ? FW'(N_FIELDS) : en_count - FW'(1);
        end
      end
      HOLD, REPEAT: begin
        if (mode_edge) begin
          state_d = IDLE;
        end else if (dir == DIR_NONE) begin
          state_d = EDIT;
        end else if (dir != dir_prev) begin
          pulse   = 1'b1;
          timer_d = '0;
          state_d = HOLD;
        end else if (timer_q == ((state_q == HOLD) ? TW'(REPEAT_DELAY - 1)
                                                   : TW'(REPEAT_PERIOD - 1))) begin
          pulse   = 1'b1;
          timer_d = '0;
          state_d = REPEAT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) begin
      field_d = '0;
      timer_d = '0;
    end
    up_d   = pulse && (dir == DIR_UP);
    down_d = pulse && (dir == DIR_DOWN);
  end

  // Blink runs only while edit mode persists; cleared on entry and exit
  always_comb begin
    bcnt_d  = '0;
    blink_d = 1'b0;
    if (state_q != IDLE && state_d != IDLE) begin
      if (bcnt_q == BW'(BLINK_HALF - 1)) begin
        bcnt_d  = '0;
        blink_d = !blink;
      end else begin
        bcnt_d  = bcnt_q + BW'(1);
        blink_d = blink;
      end
    end
  end

  always_ff @(posedge clk) begin
    mode_q  <= btn_mode;
    left_q  <= btn_left;
    right_q <= btn_right;
    up_q    <= btn_up;
    down_q  <= btn_down;
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      bcnt_q   <= '0;
      en_count <= '0;
      enUP     <= 1'b0;
      enDOWN   <= 1'b0;
      editing  <= 1'b0;
      blink    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bcnt_q   <= bcnt_d;
      en_count <= field_d;
      enUP     <= up_d;
      enDOWN   <= down_d;
      editing  <= (state_d != IDLE);
      blink    <= blink_d;
    end
  end

endmodule

// File: tb/tb_ctrl_ajuste_campos.sv
// Directed bench for ctrl_ajuste_campos: an edge-time model of the edit rules
// checked every cycle, plus hand-computed literal expectations.
module tb_ctrl_ajuste_campos;

  localparam int unsigned D  = 10;
  localparam int unsigned P  = 4;
  localparam int unsigned BH = 8;
  localparam int unsigned NF = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bm = 1'b1, bl = 1'b1, br = 1'b1, bu = 1'b1, bd = 1'b1;
  logic [3:0] en_count;
  logic       enUP, enDOWN, editing, blink;

  ctrl_ajuste_campos #(
    .N_FIELDS(NF), .REPEAT_DELAY(D), .REPEAT_PERIOD(P), .BLINK_HALF(BH)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_mode(bm), .btn_left(bl), .btn_right(br), .btn_up(bu), .btn_down(bd),
    .en_count(en_count), .enUP(enUP), .enDOWN(enDOWN), .editing(editing), .blink(blink)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Model: elapsed time since the current press decides each pulse
  int cyc = 0;
  bit valid = 0;
  bit m_edit = 0;
  int m_field = 0, m_active = 0, m_start = 0, m_entry = 0;
  bit pm = 0, pl = 0, pr = 0;
  int pdir = 0;
  bit e_up = 0, e_dn = 0, e_blink = 0;
  int e_en = 0;

  function automatic int dir_of(input bit u, input bit d);
    if (u && !d) return 1;
    if (d && !u) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin
    int dir, el;
    bit pulse, was_active;
    cyc++;
    dir   = dir_of(bu, bd);
    pulse = 0;
    if (reset) begin
      m_edit = 0;
      m_active = 0;
      valid = 1;
    end else if (bm && !pm) begin
      m_edit = !m_edit;
      m_active = 0;
      if (m_edit) begin
        m_field = 1;
        m_entry = cyc;
      end
    end else if (m_edit) begin
      was_active = (m_active != 0);
      if (dir == 0) begin
        if (!was_active && br && !pr && !(bl && !pl))
          m_field = m_field % NF + 1;
        else if (!was_active && bl && !pl && !(br && !pr))
          m_field = (m_field == 1) ? NF : m_field - 1;
        m_active = 0;
      end else if (dir != pdir && (was_active || pdir == 0)) begin
        m_active = dir;
        m_start  = cyc;
      end
      if (m_active != 0) begin
        el = cyc - m_start;
        pulse = (el == 0) || (el == D) || (el > D && (el - D) % P == 0);
      end
    end
    e_up    = pulse && m_active == 1;
    e_dn    = pulse && m_active == 2;
    e_en    = m_edit ? m_field : 0;
    e_blink = m_edit ? (((cyc - m_entry) / BH) % 2 == 1) : 1'b0;
    pm = bm; pl = bl; pr = br;
    pdir = dir;
  end

  int upq[$];
  int dn_cnt = 0;

  always @(negedge clk) begin
    if (valid) begin
      check("en_count", int'(en_count), e_en);
      check("enUP",     int'(enUP),     int'(e_up));
      check("enDOWN",   int'(enDOWN),   int'(e_dn));
      check("editing",  int'(editing),  int'(e_en != 0));
      check("blink",    int'(blink),    int'(e_blink));
      check("one_hot_pulse", int'(enUP && enDOWN), 0);
      if (enUP) upq.push_back(cyc);
      if (enDOWN) dn_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0 mode, 1 left, 2 right, 3 up, 4 down
  task automatic set_btn(input int which, input logic v);
    case (which)
      0: bm = v;
      1: bl = v;
      2: br = v;
      3: bu = v;
      default: bd = v;
    endcase
  endtask

  task automatic tap(input int which);
    set_btn(which, 1'b1);
    tick(1);
    set_btn(which, 1'b0);
    tick(1);
  endtask

  initial begin
    int k, j, d0;
    int exp_up[5];
    tick(3);
    reset = 1'b0;
    tick(1);
    check("lit_reset_en", int'(en_count), 0);
    check("lit_reset_edit", int'(editing), 0);
    tick(3);
    bm = 0; bl = 0; br = 0; bu = 0; bd = 0;
    tick(2);
    check("lit_no_pulse_after_reset", upq.size() + dn_cnt, 0);

    tap(0);
    check("lit_enter_edit", int'(editing), 1);
    check("lit_field_1", int'(en_count), 1);
    tap(2); check("lit_right_2", int'(en_count), 2);
    tap(2); check("lit_right_3", int'(en_count), 3);
    tap(2); check("lit_right_wrap_1", int'(en_count), 1);
    tap(1); check("lit_left_wrap_3", int'(en_count), 3);
    tap(2); tap(2);
    check("lit_field_2", int'(en_count), 2);

    upq.delete();
    tap(3);
    check("lit_single_up", upq.size(), 1);
    d0 = dn_cnt;
    tap(4);
    check("lit_single_down", dn_cnt - d0, 1);

    // Hold up for 25 sampled edges
    upq.delete();
    k = cyc + 1;
    bu = 1'b1;
    tick(25);
    bu = 1'b0;
    tick(10);
    exp_up = '{0, 10, 14, 18, 22};
    check("lit_hold_count", upq.size(), 5);
    for (int i = 0; i < 5; i++)
      check("lit_hold_edge", (i < upq.size()) ? upq[i] - k : -1, exp_up[i]);

    // Both held, then release down
    upq.delete();
    d0 = dn_cnt;
    bu = 1'b1; bd = 1'b1;
    tick(6);
    check("lit_both_no_pulse", upq.size() + dn_cnt - d0, 0);
    bd = 1'b0;
    tick(1);
    j = cyc;
    check("lit_release_down_up", int'(enUP), 1);
    tick(11);
    check("lit_repeat_started", (upq.size() > 1) ? upq[1] - j : -1, int'(D));
    bm = 1'b1;
    tick(1);
    check("lit_exit_en", int'(en_count), 0);
    check("lit_exit_edit", int'(editing), 0);
    check("lit_exit_blink", int'(blink), 0);
    check("lit_exit_nopulse", int'(enUP), 0);
    bm = 1'b0; bu = 1'b0;
    tick(2);

    tap(0);
    check("lit_reenter_field", int'(en_count), 1);
    tick(6); check("lit_blink_e7", int'(blink), 0);
    tick(1); check("lit_blink_e8", int'(blink), 1);
    tick(8); check("lit_blink_e16", int'(blink), 0);

    // Reset in the middle of auto-repeat with up held through it
    bu = 1'b1;
    tick(15);
    reset = 1'b1;
    tick(1);
    check("lit_reset_stops", int'(enUP), 0);
    tick(2);
    upq.delete();
    reset = 1'b0;
    tick(12);
    check("lit_held_through_reset", upq.size(), 0);
    bu = 1'b0;
    tick(3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
